// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage PC with its return-address stack.
package pc_pkg;
  localparam int PC_ADDR_W_DEFAULT = 12;

  typedef enum logic [1:0] {
    PC_NEXT = 2'b00,
    PC_JUMP = 2'b01,
    PC_CALL = 2'b10,
    PC_RET  = 2'b11
  } pc_op_t;
endpackage

// File: rtl/ret_stack.sv
// LIFO return-address storage with occupancy count; circular overwrite of the
// oldest entry when full is enabled by the PC_STACK_WRAP_EN macro.
module ret_stack
  import pc_pkg::*;
#(
  parameter int ADDR_W = PC_ADDR_W_DEFAULT,
  parameter int DEPTH  = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  sp_q, sp_d, sp_last;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_en;

  // Pointer arithmetic wraps at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_W'(DEPTH - 1) : p - PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign sp_last = ptr_dec(sp_q);
  assign top     = empty ? '0 : mem[sp_last];
  assign count   = count_q;

  always_comb begin
    sp_d    = sp_q;
    count_d = count_q;
    wr_en   = 1'b0;
    if (push && !full) begin
      wr_en   = 1'b1;
      sp_d    = ptr_inc(sp_q);
      count_d = count_q + CNT_W'(1);
    end
`ifdef PC_STACK_WRAP_EN
    else if (push) begin
      // When full, sp_q points at the oldest entry, so this overwrites it.
      wr_en = 1'b1;
      sp_d  = ptr_inc(sp_q);
    end
`endif
    else if (pop && !empty) begin
      sp_d    = sp_last;
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q    <= '0;
      count_q <= '0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[sp_q] <= din;
  end
endmodule

// File: rtl/pc_ret_stack.sv
// Program counter with CALL/RET return-address stack and sticky ovf/unf flags.
// Build option: PC_STACK_WRAP_EN makes the stack circular on overflow.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int ADDR_W = PC_ADDR_W_DEFAULT,
  parameter int DEPTH  = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] target,
  input  logic              flag_clr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              unf
);
  pc_op_t            op_e;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              push_req, pop_req;

  assign op_e   = pc_op_t'(op);
  assign pc_inc = pc_q + ADDR_W'(1);

  ret_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop_req),
    .din   (pc_inc),
    .top   (top),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    pc_d     = pc_q;
    push_req = 1'b0;
    pop_req  = 1'b0;
    // Clear first so a coincident new event still sets the flag.
    ovf_d    = ovf_q & ~flag_clr;
    unf_d    = unf_q & ~flag_clr;
    if (!stall) begin
      case (op_e)
        PC_NEXT: pc_d = pc_inc;
        PC_JUMP: pc_d = target;
        PC_CALL: begin
          pc_d     = target;
          push_req = 1'b1;
          if (full) ovf_d = 1'b1;
        end
        PC_RET: begin
          if (!empty) begin
            pc_d    = top;
            pop_req = 1'b1;
          end else begin
            pc_d  = pc_inc;
            unf_d = 1'b1;
          end
        end
        default: pc_d = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign pc  = pc_q;
  assign ovf = ovf_q;
  assign unf = unf_q;
endmodule

// File: tb/tb_pc_ret_stack.sv
// Self-checking bench for pc_ret_stack against a queue-based reference model.
module tb_pc_ret_stack;
  import pc_pkg::*;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst, stall, flag_clr;
  logic [1:0]        op;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc, top;
  logic [CNT_W-1:0]  count;
  logic              full, empty, ovf, unf;

  int n_cmp = 0;
  int n_err = 0;

  logic [ADDR_W-1:0] m_pc;
  logic [ADDR_W-1:0] m_q[$];
  logic              m_ovf, m_unf;

  always #5 clk = ~clk;

  pc_ret_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .op(op), .target(target),
    .flag_clr(flag_clr), .pc(pc), .top(top), .count(count),
    .full(full), .empty(empty), .ovf(ovf), .unf(unf)
  );

  // Apply one cycle of inputs, advance the reference model, settle past the edge.
  task automatic step(input logic r, input logic s, input pc_op_t o,
                      input logic [ADDR_W-1:0] t, input logic c);
    rst = r; stall = s; op = o; target = t; flag_clr = c;
    @(posedge clk);
    if (r) begin
      m_pc = '0; m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (c) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (!s) begin
        case (o)
          PC_NEXT: m_pc = m_pc + 1'b1;
          PC_JUMP: m_pc = t;
          PC_CALL: begin
            if (m_q.size() < DEPTH) m_q.push_back(m_pc + 1'b1);
            else begin
              m_ovf = 1'b1;
`ifdef PC_STACK_WRAP_EN
              void'(m_q.pop_front());
              m_q.push_back(m_pc + 1'b1);
`endif
            end
            m_pc = t;
          end
          PC_RET: begin
            if (m_q.size() > 0) m_pc = m_q.pop_back();
            else begin m_pc = m_pc + 1'b1; m_unf = 1'b1; end
          end
          default: ;
        endcase
      end
    end
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] m_top();
    return (m_q.size() > 0) ? m_q[$] : '0;
  endfunction

  task automatic test_reset();
    step(1, 0, PC_NEXT, '0, 0);
    step(1, 0, PC_NEXT, '0, 0);
    n_cmp++; if (pc !== 12'h000) begin n_err++; $display("FAIL reset_pc got %h want 000", pc); end
    n_cmp++; if (count !== '0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL reset_empty_full got %b%b want 10", empty, full); end
    n_cmp++; if (ovf !== 1'b0 || unf !== 1'b0) begin n_err++; $display("FAIL reset_flags got %b%b want 00", ovf, unf); end
    n_cmp++; if (top !== 12'h000) begin n_err++; $display("FAIL reset_top got %h want 000", top); end
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, PC_NEXT, $urandom, 0);
      n_cmp++; if (pc !== ADDR_W'(i)) begin n_err++; $display("FAIL next_pc%0d got %h want %h", i, pc, ADDR_W'(i)); end
    end
    n_cmp++; if (empty !== 1'b1 || count !== '0) begin n_err++; $display("FAIL next_empty got %b/%0d want 1/0", empty, count); end
  endtask

  task automatic test_call_ret();
    step(0, 0, PC_JUMP, 12'h010, 0);
    step(0, 0, PC_CALL, 12'h200, 0);
    n_cmp++; if (pc !== 12'h200) begin n_err++; $display("FAIL call_pc got %h want 200", pc); end
    n_cmp++; if (top !== 12'h011) begin n_err++; $display("FAIL call_top got %h want 011", top); end
    n_cmp++; if (count !== CNT_W'(1)) begin n_err++; $display("FAIL call_count got %0d want 1", count); end
    step(0, 0, PC_NEXT, '0, 0);
    n_cmp++; if (pc !== 12'h201) begin n_err++; $display("FAIL call_next_pc got %h want 201", pc); end
    step(0, 0, PC_RET, '0, 0);
    n_cmp++; if (pc !== 12'h011) begin n_err++; $display("FAIL ret_pc got %h want 011", pc); end
    n_cmp++; if (count !== '0 || empty !== 1'b1) begin n_err++; $display("FAIL ret_count got %0d/%b want 0/1", count, empty); end
  endtask

  task automatic test_overflow();
    step(0, 0, PC_JUMP, 12'h000, 0);
    for (int i = 0; i <= DEPTH; i++) step(0, 0, PC_CALL, 12'h100, 0);
    n_cmp++; if (full !== 1'b1 || ovf !== 1'b1) begin n_err++; $display("FAIL ovf_full_flag got %b%b want 11", full, ovf); end
    n_cmp++; if (count !== CNT_W'(DEPTH)) begin n_err++; $display("FAIL ovf_count got %0d want %0d", count, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, PC_RET, '0, 0);
      n_cmp++; if (pc !== m_pc) begin n_err++; $display("FAIL ovf_pop%0d got %h want %h", i, pc, m_pc); end
    end
`ifdef PC_STACK_WRAP_EN
    n_cmp++; if (pc !== 12'h101) begin n_err++; $display("FAIL ovf_last_pop got %h want 101", pc); end
`else
    n_cmp++; if (pc !== 12'h001) begin n_err++; $display("FAIL ovf_last_pop got %h want 001", pc); end
`endif
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL ovf_drained got %b want 1", empty); end
  endtask

  task automatic test_underflow();
    step(0, 0, PC_JUMP, 12'h0FF, 1);
    step(0, 0, PC_RET, '0, 0);
    n_cmp++; if (pc !== 12'h100 || unf !== 1'b1) begin n_err++; $display("FAIL unf_set got %h/%b want 100/1", pc, unf); end
    step(0, 0, PC_NEXT, '0, 1);
    n_cmp++; if (unf !== 1'b0) begin n_err++; $display("FAIL unf_clr got %b want 0", unf); end
    step(0, 0, PC_RET, '0, 1);
    n_cmp++; if (unf !== 1'b1) begin n_err++; $display("FAIL unf_set_wins got %b want 1", unf); end
  endtask

  task automatic test_wrap_stall();
    logic [ADDR_W-1:0] pc_hold;
    logic [CNT_W-1:0]  cnt_hold;
    step(0, 0, PC_JUMP, 12'hFFF, 0);
    step(0, 0, PC_NEXT, '0, 0);
    n_cmp++; if (pc !== 12'h000) begin n_err++; $display("FAIL pc_wrap got %h want 000", pc); end
    step(0, 0, PC_CALL, 12'h055, 0);
    pc_hold = m_pc; cnt_hold = CNT_W'(m_q.size());
    for (int i = 0; i < 3; i++) begin
      step(0, 1, PC_CALL, 12'h3AA, 0);
      n_cmp++; if (pc !== pc_hold || count !== cnt_hold) begin n_err++; $display("FAIL stall%0d got %h/%0d want %h/%0d", i, pc, count, pc_hold, cnt_hold); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(0, 0, PC_CALL, 12'h300, 0);
    step(1, 0, PC_RET, '0, 0);
    n_cmp++; if (pc !== '0 || count !== '0 || empty !== 1'b1) begin n_err++; $display("FAIL midrst got %h/%0d/%b want 000/0/1", pc, count, empty); end
    step(0, 0, PC_RET, '0, 0);
    n_cmp++; if (unf !== 1'b1 || pc !== 12'h001) begin n_err++; $display("FAIL midrst_ret got %b/%h want 1/001", unf, pc); end
  endtask

  task automatic test_random();
    pc_op_t o;
    for (int i = 0; i < 600; i++) begin
      o = pc_op_t'($urandom_range(0, 3));
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 20), o,
           ADDR_W'($urandom), ($urandom_range(0, 99) < 10));
      n_cmp++;
      if (pc !== m_pc || top !== m_top() || count !== CNT_W'(m_q.size()) ||
          full !== (m_q.size() == DEPTH) || empty !== (m_q.size() == 0) ||
          ovf !== m_ovf || unf !== m_unf) begin
        n_err++;
        $display("FAIL rand%0d got pc=%h top=%h cnt=%0d f=%b e=%b o=%b u=%b want pc=%h top=%h cnt=%0d o=%b u=%b",
                 i, pc, top, count, full, empty, ovf, unf, m_pc, m_top(), m_q.size(), m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; op = PC_NEXT; target = '0; flag_clr = 1'b0;
    m_pc = '0; m_ovf = 1'b0; m_unf = 1'b0;
    test_reset();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_wrap_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pc_ret_stack.md
Name: pc_ret_stack

Overview:
Parametrised program-counter register with a built-in hardware return-address stack (LIFO) for CALL/RET.
- Sits in the fetch stage. Drives the instruction-memory address and replaces the bare PC register.
- Adds stall, jump, call and return modes, plus stack full/empty status and sticky overflow/underflow flags.

Parameters:
ADDR_W, 12, width of PC, jump target and stack entries
DEPTH, 8, number of return-address entries (>=2)
CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; synchronous, active-high
stall  input  1  hold PC and stack; op ignored
op  input  2  pc_op_t: PC_NEXT, PC_JUMP, PC_CALL, PC_RET
target  input  ADDR_W  jump/call destination
flag_clr  input  1  clears sticky ovf/unf
pc  output  ADDR_W  current PC (registered)
top  output  ADDR_W  stack top entry; 0 when empty
count  output  CNT_W  number of valid entries
full  output  1  count == DEPTH
empty  output  1  count == 0
ovf  output  1  sticky: CALL attempted while full
unf  output  1  sticky: RET attempted while empty

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. Reset has priority over every other input.
- Reset values: pc=0, count=0, top=0, full=0, empty=1, ovf=0, unf=0. Storage contents are don't-care.
- stall=1: pc, stack and count hold. flag_clr is still honoured.
- stall=0, per op:
  - PC_NEXT: pc <= pc+1, modulo 2^ADDR_W (wraps from all-ones to 0).
  - PC_JUMP: pc <= target. Stack unchanged.
  - PC_CALL, not full: push (pc+1 mod 2^ADDR_W), count+1, pc <= target.
  - PC_CALL, full: pc <= target, stack unchanged, ovf <= 1 (see optional feature).
  - PC_RET, not empty: pc <= top, pop, count-1.
  - PC_RET, empty: pc <= pc+1, unf <= 1, count stays 0.
- Latency: every update appears on pc/top/count one cycle after the sampling edge. No combinational input-to-output path.
- full, empty and top are combinational decodes of registered state only.
- flag_clr in the same cycle as a new overflow or underflow event: the set wins and the flag stays 1.
- A push on one call and a pop on the next cycle return the pushed value exactly, back to back with no bubble.
- Reset mid-sequence discards all stacked entries. The next RET underflows.

Optional Feature:
Macro PC_STACK_WRAP_EN.
- Defined: the stack is circular. CALL while full overwrites the oldest entry, pushes pc+1 and keeps count == DEPTH. ovf is still set.
- Not defined: CALL while full drops the push, as specified above.
- All other behaviour is identical in both builds.

Decomposition:
- Package pc_pkg:
  - typedef enum logic [1:0] pc_op_t {PC_NEXT=2'b00, PC_JUMP=2'b01, PC_CALL=2'b10, PC_RET=2'b11}
  - localparam PC_ADDR_W_DEFAULT = 12
- Sub-module ret_stack (storage array, pointer, count, push/pop/full/empty, wrap option).
- The top level holds the pc register, op decode and sticky flags.

Test Plan:
- Reset then 5 cycles PC_NEXT -> pc 0,1,2,3,4,5; empty=1, count=0, ovf=unf=0.
- pc=0x010, PC_CALL target=0x200, then PC_NEXT, PC_RET -> pc 0x200, 0x201, 0x011; top=0x011 after the call; count 1 then 0.
- DEPTH+1 nested CALLs from pc=0x000, target=0x100 each -> full=1, ovf=1, count=8. Then 8 RETs pop 0x101..0x101,0x001 in LIFO order.
  - With PC_STACK_WRAP_EN: the oldest entry 0x001 is lost.
- PC_RET with empty stack at pc=0x0FF -> pc=0x100, unf=1. flag_clr next cycle -> unf=0. flag_clr coinciding with a second empty RET -> unf stays 1.
- pc=0xFFF, PC_NEXT -> pc=0x000. stall=1 with PC_CALL held 3 cycles -> pc, count unchanged.
- Three CALLs, then rst=1 for one cycle concurrent with PC_RET -> pc=0, count=0, empty=1. The following RET sets unf.
